// File: rtl/cipher_interface_fsm.sv
// Stream cipher top-level sequencer: synchronises user strobe/ack levels, issues key and
// data bytes to the cipher, waits for the output holder and reports protocol errors.
module cipher_interface_fsm #(
  parameter int unsigned KEY_BYTES   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       strobe_in,
  input  logic       ack_in,
  input  logic       mode_key_in,
  input  logic       output_holder_state,
  output logic [7:0] key_byte,
  output logic       key_byte_pulse,
  output logic [3:0] key_idx,
  output logic [7:0] data_byte,
  output logic       data_byte_pulse,
  output logic [2:0] interface_state,
  output logic       key_loaded,
  output logic       out_sel,
  output logic       err_timeout,
  output logic       err_nokey,
  output logic       overrun
);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StIssue      = 3'd1,
    StWaitCipher = 3'd2,
    StWaitRead   = 3'd3,
    StError      = 3'd4
  } interface_state_t;

  localparam logic       HolderReady = 1'b1;
  localparam logic [3:0] KeyCount    = 4'(KEY_BYTES);
  localparam logic [7:0] TmoLast     = 8'(TIMEOUT_CYC - 1);

  interface_state_t state;
  logic             strobe_s1, strobe_s2, strobe_s3;
  logic             ack_s1, ack_s2, ack_s3;
  logic [3:0]       key_cnt;
  logic [7:0]       tmo_cnt;
  logic             strobe_rise, ack_rise;
  logic [3:0]       key_next;

  assign interface_state = state;

  // Edge detection on synchronised levels and the next key count (a reload restarts at 0).
  always_comb begin
    strobe_rise = strobe_s2 & ~strobe_s3;
    ack_rise    = ack_s2 & ~ack_s3;
    key_next    = (key_loaded ? 4'd0 : key_cnt) + 4'd1;
  end

  // Synchronisers, sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_s1       <= 1'b0;
      strobe_s2       <= 1'b0;
      strobe_s3       <= 1'b0;
      ack_s1          <= 1'b0;
      ack_s2          <= 1'b0;
      ack_s3          <= 1'b0;
      state           <= StIdle;
      key_cnt         <= 4'd0;
      tmo_cnt         <= 8'd0;
      key_byte        <= 8'd0;
      key_byte_pulse  <= 1'b0;
      key_idx         <= 4'd0;
      data_byte       <= 8'd0;
      data_byte_pulse <= 1'b0;
      key_loaded      <= 1'b0;
      out_sel         <= 1'b0;
      err_timeout     <= 1'b0;
      err_nokey       <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      strobe_s1       <= strobe_in;
      strobe_s2       <= strobe_s1;
      strobe_s3       <= strobe_s2;
      ack_s1          <= ack_in;
      ack_s2          <= ack_s1;
      ack_s3          <= ack_s2;
      key_byte_pulse  <= 1'b0;
      data_byte_pulse <= 1'b0;

      unique case (state)
        StIdle: begin
          if (ack_rise) overrun <= 1'b0;
          if (strobe_rise) begin
            if (mode_key_in) begin
              key_byte       <= data_in;
              key_idx        <= key_loaded ? 4'd0 : key_cnt;
              key_byte_pulse <= 1'b1;
              if (key_next == KeyCount) begin
                key_loaded <= 1'b1;
                key_cnt    <= 4'd0;
              end else begin
                key_loaded <= 1'b0;
                key_cnt    <= key_next;
              end
            end else if (key_loaded) begin
              data_byte       <= data_in;
              data_byte_pulse <= 1'b1;
              state           <= StIssue;
            end else begin
              err_nokey <= 1'b1;
              state     <= StError;
            end
          end
        end
        StIssue: begin
          tmo_cnt <= 8'd0;
          state   <= StWaitCipher;
        end
        StWaitCipher: begin
          // Holder readiness takes priority over an expiring timeout.
          if (output_holder_state == HolderReady) begin
            out_sel <= 1'b1;
            state   <= StWaitRead;
          end else if (tmo_cnt == TmoLast) begin
            err_timeout <= 1'b1;
            state       <= StError;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        StWaitRead: begin
          if (ack_rise) begin
            out_sel <= 1'b0;
            state   <= StIdle;
          end
        end
        StError: begin
          if (ack_rise) begin
            err_timeout <= 1'b0;
            err_nokey   <= 1'b0;
            overrun     <= 1'b0;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase

      // Placed after the case so a dropped strobe wins over a same-cycle ack clear.
      if (strobe_rise && state != StIdle) overrun <= 1'b1;
    end
  end

endmodule
